pulse_gen: RTL
==============

# pulse_gen

Step/direction pulse generator for the six-axis stepper controller. It sits directly downstream of the control stage and consumes its motor select, pulse count and direction outputs. For each accepted move it drives a fixed-period STEP pulse train on the selected motor and holds the motor's DIR line. It raises `Busy` back to the control stage for the whole move, so no new command is computed mid-move.

## Interface
Parameters:
- `PERIOD`, default 1000: sysclk cycles per step pulse (high plus low). Must be ≥ 2.
- `PW`, default 500: sysclk cycles STEP is high. Requires 1 ≤ PW < PERIOD.
- `DIR_SETUP`, default 50: cycles DIR is stable before the first STEP rising edge. Must be ≥ 1.

Ports:
- `sysclk`  in  1  system clock. Single clock domain.
- `rst_n`  in  1  asynchronous reset, active-low.
- `MotorIn`  in  6  one-hot motor select from the control stage.
- `PulseNum`  in  10  number of step pulses to issue.
- `DRIn`  in  6  per-motor direction (1 = reverse, 0 = forward).
- `Busy`  out  1  high from acceptance through the DONE state.
- `PUL`  out  6  STEP outputs, one per motor.
- `DR`  out  6  DIR outputs, one per motor.
- `Done`  out  1  one-cycle pulse when a move completes.

## Operation
- Each cycle, input registers `s_motor`, `s_num` and `s_dr` sample `MotorIn`, `PulseNum` and `DRIn`.
- Last-accepted registers `a_motor`, `a_num` and `a_dr` hold the most recent accepted command.
- Accept condition, evaluated in IDLE only. All of the following must be true:
  - inputs equal the `s_*` samples (stable for ≥ 2 cycles);
  - `MotorIn` is exactly one-hot;
  - `PulseNum` ≠ 0;
  - the input triple ≠ the `a_*` triple.
- If the condition fails, the command is ignored. A repeated identical command (same motor, count and direction) is treated as one command by design.
- On accept:
  - latch the triple into `a_*`;
  - load the remaining-pulse counter `rem` with `PulseNum`;
  - set `DR[i]` to `DRIn[i]` for the selected bit i; other `DR` bits hold;
  - go to SETUP.
- FSM states:
  - IDLE: Busy=0. Moves to SETUP on accept.
  - SETUP: lasts DIR_SETUP cycles, PUL=0. Then goes to HIGH.
  - HIGH: lasts PW cycles, PUL = `a_motor`. Then goes to LOW.
  - LOW: lasts PERIOD−PW cycles, PUL=0. At its end, decrement `rem`. If the new value ≠ 0, go to HIGH; otherwise go to DONE.
  - DONE: one cycle, Done=1, Busy=1. Then goes to IDLE.
- Input changes during non-IDLE states are ignored. They are evaluated again on return to IDLE.
- Only one motor moves at a time. `PUL` is either zero or one-hot.

## Timing
- All outputs are registered.
- Reset values: Busy=0, Done=0, PUL=0, DR=0. The FSM, counters, `s_*` and `a_*` registers all reset to 0.
- Accept latency: inputs change at edge t. The stable-check passes at edge t+1. Busy=1 and the new DR value are visible after edge t+2.
- Busy stays high for exactly DIR_SETUP + N·PERIOD + 1 cycles, where N = `PulseNum`.
- The first PUL rise occurs DIR_SETUP cycles after Busy rises.
- Done is high in the final Busy cycle. Busy falls on the next edge.
- Timer counter width is $clog2(max(PERIOD, DIR_SETUP)+1). `rem` is 10 bits and never underflows, because entry to DONE is checked before a decrement would wrap.
- Asserting `rst_n` mid-move forces PUL and DR low immediately, without waiting for a clock. After release the block is in IDLE, and the pending input triple is accepted again if it is valid, since `a_*` was cleared.

## Structure
- Shared package `pulse_pkg` contains:
  - state enum (IDLE, SETUP, HIGH, LOW, DONE);
  - `MOTOR_W` = 6 and `COUNT_W` = 10;
  - function `is_onehot6`.
- Optional sub-module `step_timer`: a loadable down-counter with a terminal-count flag, reused for the SETUP, HIGH and LOW durations.

## Test plan
Use PERIOD=4, PW=2, DIR_SETUP=2 for all scenarios.
- Basic move: Motor=6'b000100, PulseNum=3, DRIn=6'b000100, held stable → DR[2]=1. Busy high for 15 cycles. Three PUL[2] pulses, each 2 cycles high and 2 low. Done for one cycle. Other PUL bits stay 0.
- Invalid commands: Motor=6'b000011 or 6'b000000, or PulseNum=0 → Busy stays 0. No PUL activity.
- Repeated command: the same triple re-presented after Done → no second move. A changed PulseNum of 5 → a 5-pulse move.
- Glitch filter: input held for only 1 cycle → ignored. Inputs changed mid-move → ignored until IDLE, then accepted.
- Reset mid-move: `rst_n` low during HIGH → PUL=0 and DR=0 asynchronously. After release, Busy=0, then the stable input triple is re-accepted.
- Max count: PulseNum=1023 → exactly 1023 pulses, Busy lasting 4095 cycles, no counter wrap.

Source files
------------

// File: rtl/pulse_pkg.sv
// pulse_pkg: shared types and helpers for the step/direction pulse generator.
//   state_e    - move sequencer states (IDLE, SETUP, HIGH, LOW, DONE)
//   MOTOR_W    - number of motor channels
//   COUNT_W    - width of the step-count field
//   is_onehot6 - true when exactly one motor-select bit is set
package pulse_pkg;

  localparam int MOTOR_W = 6;
  localparam int COUNT_W = 10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Population count of exactly one across the motor-select bits.
  function automatic logic is_onehot6(input logic [MOTOR_W-1:0] v);
    logic [2:0] ones;
    ones = 3'd0;
    for (int i = 0; i < MOTOR_W; i++) begin
      ones = ones + {2'b00, v[i]};
    end
    return (ones == 3'd1);
  endfunction

endpackage

// File: rtl/step_timer.sv
// step_timer: loadable down-counter used to time the SETUP, HIGH and LOW
// phases of a move. Loading value V makes tc assert V cycles later, so a
// phase of L cycles is timed by loading L-1 on the edge that enters it.
//   clk, rst_n - clock and asynchronous active-low reset
//   load       - load load_val this cycle (takes priority over counting)
//   load_val   - value to load
//   tc         - terminal count: counter is at zero
module step_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load wins, otherwise count down and rest at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != {W{1'b0}}) begin
      cnt_d = cnt_q - W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/pulse_gen.sv
// pulse_gen: step/direction pulse generator for a six-axis stepper
// controller. A command (motor, count, direction) that has been stable for
// two cycles, is valid and differs from the last accepted one starts a move:
// DIR of the selected motor is updated, DIR_SETUP cycles later a train of
// PulseNum STEP pulses (PW high, PERIOD-PW low) is issued, then Done pulses.
//   sysclk   - system clock
//   rst_n    - asynchronous active-low reset (clears PUL and DR at once)
//   MotorIn  - one-hot motor select
//   PulseNum - number of step pulses, zero is ignored
//   DRIn     - per-motor direction (1 = reverse)
//   Busy     - high from acceptance through the DONE cycle
//   PUL      - STEP outputs, zero or one-hot
//   DR       - DIR outputs, only the selected motor's bit changes per move
//   Done     - one-cycle pulse in the last Busy cycle
module pulse_gen
  import pulse_pkg::*;
#(
  parameter int PERIOD    = 1000,
  parameter int PW        = 500,
  parameter int DIR_SETUP = 50
) (
  input  logic               sysclk,
  input  logic               rst_n,
  input  logic [MOTOR_W-1:0] MotorIn,
  input  logic [COUNT_W-1:0] PulseNum,
  input  logic [MOTOR_W-1:0] DRIn,
  output logic               Busy,
  output logic [MOTOR_W-1:0] PUL,
  output logic [MOTOR_W-1:0] DR,
  output logic               Done
);

  localparam int TMAX = (PERIOD > DIR_SETUP) ? PERIOD : DIR_SETUP;
  localparam int TW   = $clog2(TMAX + 1);

  // Timer reload values are duration-1 because the load edge starts the phase.
  localparam logic [TW-1:0] SETUP_LD = TW'(DIR_SETUP - 1);
  localparam logic [TW-1:0] HIGH_LD  = TW'(PW - 1);
  localparam logic [TW-1:0] LOW_LD   = TW'(PERIOD - PW - 1);

  state_e             state_q, state_d;
  logic [MOTOR_W-1:0] s_motor_q, s_motor_d;
  logic [COUNT_W-1:0] s_num_q, s_num_d;
  logic [MOTOR_W-1:0] s_dr_q, s_dr_d;
  logic [MOTOR_W-1:0] a_motor_q, a_motor_d;
  logic [COUNT_W-1:0] a_num_q, a_num_d;
  logic [MOTOR_W-1:0] a_dr_q, a_dr_d;
  logic [COUNT_W-1:0] rem_q, rem_d;
  logic [MOTOR_W-1:0] dr_q, dr_d;
  logic [MOTOR_W-1:0] pul_q, pul_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               accept;
  logic               tmr_load;
  logic [TW-1:0]      tmr_val;
  logic               tmr_tc;

  step_timer #(.W(TW)) u_timer (
    .clk      (sysclk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  // Sequencer next state, command capture and registered-output next values.
  always_comb begin
    state_d   = state_q;
    a_motor_d = a_motor_q;
    a_num_d   = a_num_q;
    a_dr_d    = a_dr_q;
    rem_d     = rem_q;
    dr_d      = dr_q;
    tmr_load  = 1'b0;
    tmr_val   = {TW{1'b0}};

    s_motor_d = MotorIn;
    s_num_d   = PulseNum;
    s_dr_d    = DRIn;

    // Stable for two samples, valid, and not the move we just performed.
    accept = (MotorIn == s_motor_q) && (PulseNum == s_num_q) && (DRIn == s_dr_q) &&
             is_onehot6(MotorIn) && (PulseNum != {COUNT_W{1'b0}}) &&
             ({MotorIn, PulseNum, DRIn} != {a_motor_q, a_num_q, a_dr_q});

    case (state_q)
      IDLE: begin
        if (accept) begin
          a_motor_d = MotorIn;
          a_num_d   = PulseNum;
          a_dr_d    = DRIn;
          rem_d     = PulseNum;
          dr_d      = (dr_q & ~MotorIn) | (DRIn & MotorIn);
          tmr_load  = 1'b1;
          tmr_val   = SETUP_LD;
          state_d   = SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        if (tmr_tc) begin
          tmr_load = 1'b1;
          tmr_val  = HIGH_LD;
          state_d  = HIGH;
        end else begin
          state_d = SETUP;
        end
      end
      HIGH: begin
        if (tmr_tc) begin
          tmr_load = 1'b1;
          tmr_val  = LOW_LD;
          state_d  = LOW;
        end else begin
          state_d = HIGH;
        end
      end
      LOW: begin
        if (tmr_tc) begin
          // rem is never zero here; the guard keeps it from wrapping regardless.
          if (rem_q != {COUNT_W{1'b0}}) begin
            rem_d = rem_q - COUNT_W'(1);
          end else begin
            rem_d = rem_q;
          end
          if (rem_d == {COUNT_W{1'b0}}) begin
            state_d = DONE;
          end else begin
            tmr_load = 1'b1;
            tmr_val  = HIGH_LD;
            state_d  = HIGH;
          end
        end else begin
          state_d = LOW;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they register with it.
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    if (state_d == HIGH) begin
      pul_d = a_motor_d;
    end else begin
      pul_d = {MOTOR_W{1'b0}};
    end
  end

  // Sequencer state, command registers and registered outputs.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      s_motor_q <= {MOTOR_W{1'b0}};
      s_num_q   <= {COUNT_W{1'b0}};
      s_dr_q    <= {MOTOR_W{1'b0}};
      a_motor_q <= {MOTOR_W{1'b0}};
      a_num_q   <= {COUNT_W{1'b0}};
      a_dr_q    <= {MOTOR_W{1'b0}};
      rem_q     <= {COUNT_W{1'b0}};
      dr_q      <= {MOTOR_W{1'b0}};
      pul_q     <= {MOTOR_W{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_motor_q <= s_motor_d;
      s_num_q   <= s_num_d;
      s_dr_q    <= s_dr_d;
      a_motor_q <= a_motor_d;
      a_num_q   <= a_num_d;
      a_dr_q    <= a_dr_d;
      rem_q     <= rem_d;
      dr_q      <= dr_d;
      pul_q     <= pul_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign Busy = busy_q;
  assign Done = done_q;
  assign PUL  = pul_q;
  assign DR   = dr_q;

endmodule
